// File: rtl/cache_pkg.sv
// Shared cache-side definitions: request command encodings, line-address width
// and a saturating counter helper.
package cache_pkg;

    localparam int LINE_ADDR_W = 26;

    typedef enum logic [1:0] {
        NOP   = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RFO   = 2'b11
    } cmd_e;

    // Adds 0..3 to a 32-bit event counter, pinning at all-ones.
    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, v} + {31'b0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/l2_req_fifo.sv
// Request storage: two write ports (port 0 lands first), one read port,
// head entry is always presented combinationally from the read pointer.
module l2_req_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 28
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr0_en,
    input  logic [W-1:0]             wr0_data,
    input  logic                     wr1_en,
    input  logic [W-1:0]             wr1_data,
    input  logic                     rd_en,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr1;
    logic [PTR_W-1:0] rd_ptr;

    assign wr_ptr1 = wr_ptr + PTR_W'(1);
    assign head    = mem[rd_ptr];

    // Storage is left uninitialised; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr_ptr]  <= wr0_data;
        if (wr1_en) mem[wr_ptr1] <= wr1_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            rd_ptr <= rd_ptr + PTR_W'(rd_en);
            count  <= count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(rd_en);
        end
    end

endmodule

// File: rtl/l2_req_queue.sv
// Merges I-cache and D-cache miss requests into one ordered queue toward L2,
// with ic priority under overflow and saturating event counters.
module l2_req_queue
    import cache_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = LINE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ic_add,
    input  logic [1:0]        ic_cmd,
    input  logic [ADDR_W-1:0] dc_add,
    input  logic [1:0]        dc_cmd,
    input  logic              l2_ready,
    output logic              l2_valid,
    output logic [ADDR_W-1:0] l2_add,
    output logic [1:0]        l2_cmd,
    output logic              full,
    output logic [31:0]       accepted,
    output logic [31:0]       dropped,
    output logic [31:0]       merged
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int W     = ADDR_W + 2;

    logic [W-1:0]     head;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;
    logic [CNT_W-1:0] count_nxt;
    logic             deq;
    logic             ic_req;
    logic             dc_req;
    logic             merge;
    logic             dc_new;
    logic             ic_wr;
    logic             dc_wr;
    logic [1:0]       n_acc;
    logic [1:0]       n_drop;

    assign l2_valid = (count != '0);
    assign {l2_cmd, l2_add} = l2_valid ? head : '0;

    assign deq    = l2_valid && l2_ready;
    assign ic_req = (ic_cmd != NOP);
    assign dc_req = (dc_cmd != NOP);
    assign merge  = ic_req && dc_req && (ic_add == dc_add) && (ic_cmd == dc_cmd);
    assign dc_new = dc_req && !merge;

    // The slot freed by this edge's dequeue is already counted as free.
    assign free   = CNT_W'(DEPTH) - count + CNT_W'(deq);
    assign ic_wr  = ic_req && (free != '0);
    assign dc_wr  = dc_new && (free > CNT_W'(ic_wr));

    assign n_acc     = 2'(ic_wr) + 2'(dc_wr);
    assign n_drop    = 2'(ic_req && !ic_wr) + 2'(dc_new && !dc_wr);
    assign count_nxt = count - CNT_W'(deq) + CNT_W'(ic_wr) + CNT_W'(dc_wr);

    // A lone dc request takes write port 0 so the FIFO stays dense.
    l2_req_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr0_en   (ic_wr || dc_wr),
        .wr0_data (ic_wr ? {ic_cmd, ic_add} : {dc_cmd, dc_add}),
        .wr1_en   (ic_wr && dc_wr),
        .wr1_data ({dc_cmd, dc_add}),
        .rd_en    (deq),
        .head     (head),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            accepted <= '0;
            dropped  <= '0;
            merged   <= '0;
        end else begin
            full     <= (count_nxt == CNT_W'(DEPTH));
            accepted <= sat_add(accepted, n_acc);
            dropped  <= sat_add(dropped, n_drop);
            merged   <= sat_add(merged, {1'b0, merge});
        end
    end

endmodule

// File: tb/tb_l2_req_queue.sv
// Directed vector table for the documented scenarios, then randomized traffic
// checked against a queue-based reference model.
module tb_l2_req_queue;
    import cache_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 26;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ic_add, dc_add, l2_add;
    logic [1:0]    ic_cmd, dc_cmd, l2_cmd;
    logic          l2_ready, l2_valid, full;
    logic [31:0]   accepted, dropped, merged;

    int checks = 0;
    int errors = 0;

    logic [AW+1:0] mq[$];
    int unsigned   m_acc, m_drop, m_merge;

    typedef struct {
        logic [AW-1:0] ia; logic [1:0] ic;
        logic [AW-1:0] da; logic [1:0] dc;
        logic          rdy;
        logic          e_valid; logic [AW-1:0] e_add; logic [1:0] e_cmd; logic e_full;
        int unsigned   e_acc, e_drop, e_merge;
    } vec_t;

    vec_t vt[16];

    l2_req_queue #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_add(ic_add), .ic_cmd(ic_cmd), .dc_add(dc_add), .dc_cmd(dc_cmd),
        .l2_ready(l2_ready), .l2_valid(l2_valid), .l2_add(l2_add), .l2_cmd(l2_cmd),
        .full(full), .accepted(accepted), .dropped(dropped), .merged(merged)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_acc = 0; m_drop = 0; m_merge = 0;
    endfunction

    // One edge of the reference: dequeue, ic, then dc (folded if identical to ic).
    function automatic void model_edge(input logic [AW-1:0] ia, input logic [1:0] ic,
                                       input logic [AW-1:0] da, input logic [1:0] dc,
                                       input logic rdy);
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (ic != 2'b00) begin
            if (mq.size() < DEPTH) begin mq.push_back({ic, ia}); m_acc++; end
            else m_drop++;
        end
        if (dc != 2'b00) begin
            if (ic == dc && ia == da) m_merge++;
            else if (mq.size() < DEPTH) begin mq.push_back({dc, da}); m_acc++; end
            else m_drop++;
        end
    endfunction

    task automatic step(input logic [AW-1:0] ia, input logic [1:0] ic,
                        input logic [AW-1:0] da, input logic [1:0] dc, input logic rdy);
        ic_add = ia; ic_cmd = ic; dc_add = da; dc_cmd = dc; l2_ready = rdy;
        model_edge(ia, ic, da, dc, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input int cyc);
        logic [AW+1:0] hd;
        logic [31:0]   act, exp;
        hd  = (mq.size() > 0) ? mq[0] : '0;
        exp = {3'b0, (mq.size() == DEPTH), (mq.size() > 0), hd[AW+1:AW], hd[AW-1:0]};
        act = {3'b0, full, l2_valid, l2_cmd, l2_add};
        chk($sformatf("rand_head_c%0d", cyc), act, exp);
        chk($sformatf("rand_acc_c%0d", cyc), accepted, m_acc);
        chk($sformatf("rand_drop_c%0d", cyc), dropped, m_drop);
        chk($sformatf("rand_merge_c%0d", cyc), merged, m_merge);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(l2_valid), 0);
        chk({tag, "_add"}, 32'(l2_add), 0);
        chk({tag, "_cmd"}, 32'(l2_cmd), 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_acc"}, accepted, 0);
        chk({tag, "_drop"}, dropped, 0);
        chk({tag, "_merge"}, merged, 0);
    endtask

    initial begin
        // ia ic da dc rdy | valid add cmd full acc drop merge
        vt[0]  = '{26'h0ABCDEF, 2'd1, 26'h0, 2'd0, 1'b1, 1'b1, 26'h0ABCDEF, 2'd1, 1'b0, 1, 0, 0};
        vt[1]  = '{26'h0, 2'd0, 26'h0, 2'd0, 1'b1, 1'b0, 26'h0, 2'd0, 1'b0, 1, 0, 0};
        vt[2]  = '{26'h100, 2'd1, 26'h200, 2'd2, 1'b0, 1'b1, 26'h100, 2'd1, 1'b0, 3, 0, 0};
        vt[3]  = '{26'h0, 2'd0, 26'h0, 2'd0, 1'b1, 1'b1, 26'h200, 2'd2, 1'b0, 3, 0, 0};
        vt[4]  = '{26'h0, 2'd0, 26'h0, 2'd0, 1'b1, 1'b0, 26'h0, 2'd0, 1'b0, 3, 0, 0};
        vt[5]  = '{26'h300, 2'd1, 26'h300, 2'd1, 1'b0, 1'b1, 26'h300, 2'd1, 1'b0, 4, 0, 1};
        vt[6]  = '{26'h0, 2'd0, 26'h0, 2'd0, 1'b1, 1'b0, 26'h0, 2'd0, 1'b0, 4, 0, 1};
        vt[7]  = '{26'h400, 2'd2, 26'h500, 2'd3, 1'b0, 1'b1, 26'h400, 2'd2, 1'b0, 6, 0, 1};
        vt[8]  = '{26'h401, 2'd2, 26'h501, 2'd3, 1'b0, 1'b1, 26'h400, 2'd2, 1'b0, 8, 0, 1};
        vt[9]  = '{26'h402, 2'd2, 26'h502, 2'd3, 1'b0, 1'b1, 26'h400, 2'd2, 1'b0, 10, 0, 1};
        vt[10] = '{26'h403, 2'd2, 26'h503, 2'd3, 1'b0, 1'b1, 26'h400, 2'd2, 1'b1, 12, 0, 1};
        vt[11] = '{26'h600, 2'd1, 26'h601, 2'd1, 1'b0, 1'b1, 26'h400, 2'd2, 1'b1, 12, 2, 1};
        vt[12] = '{26'h700, 2'd1, 26'h0, 2'd0, 1'b1, 1'b1, 26'h500, 2'd3, 1'b1, 13, 2, 1};
        vt[13] = '{26'h0, 2'd0, 26'h0, 2'd0, 1'b1, 1'b1, 26'h401, 2'd2, 1'b0, 13, 2, 1};
        vt[14] = '{26'h0, 2'd0, 26'h0, 2'd0, 1'b1, 1'b1, 26'h501, 2'd3, 1'b0, 13, 2, 1};
        vt[15] = '{26'h0, 2'd0, 26'h0, 2'd0, 1'b1, 1'b1, 26'h402, 2'd2, 1'b0, 13, 2, 1};

        rst_n = 1'b0;
        ic_add = '0; ic_cmd = 2'd0; dc_add = '0; dc_cmd = 2'd0; l2_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            step(vt[i].ia, vt[i].ic, vt[i].da, vt[i].dc, vt[i].rdy);
            chk($sformatf("v%0d_valid", i), 32'(l2_valid), 32'(vt[i].e_valid));
            chk($sformatf("v%0d_add", i), 32'(l2_add), 32'(vt[i].e_add));
            chk($sformatf("v%0d_cmd", i), 32'(l2_cmd), 32'(vt[i].e_cmd));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vt[i].e_full));
            chk($sformatf("v%0d_acc", i), accepted, vt[i].e_acc);
            chk($sformatf("v%0d_drop", i), dropped, vt[i].e_drop);
            chk($sformatf("v%0d_merge", i), merged, vt[i].e_merge);
        end

        // Five entries queued; reset mid-cycle with requests still being presented.
        ic_add = 26'h777; ic_cmd = 2'd1; dc_add = 26'h778; dc_cmd = 2'd2; l2_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_idle("async_rst");
        repeat (2) @(posedge clk);
        #1;
        chk_idle("rst_held");
        @(negedge clk);
        ic_cmd = 2'd0; dc_cmd = 2'd0;
        rst_n = 1'b1;
        step('0, 2'd0, '0, 2'd0, 1'b1);
        chk_idle("post_rst");
        step(26'h0123, 2'd3, '0, 2'd0, 1'b0);
        chk("post_rst_first_valid", 32'(l2_valid), 1);
        chk("post_rst_first_add", 32'(l2_add), 32'h0123);
        chk("post_rst_first_acc", accepted, 1);

        for (int c = 0; c < 3000; c++) begin
            logic [AW-1:0] ia, da;
            logic [1:0]    ic, dc;
            ia = 26'($urandom_range(0, 3));
            ic = 2'($urandom_range(0, 3));
            da = ($urandom_range(0, 2) == 0) ? ia : 26'($urandom_range(0, 3));
            dc = ($urandom_range(0, 2) == 0) ? ic : 2'($urandom_range(0, 3));
            step(ia, ic, da, dc, ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 3 : 8)));
            chk_model(c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
